// File: rtl/height_digit_renderer.sv
// height_digit_renderer: binary height to decimal digits (double-dabble),
// frame-synchronous digit buffer and 2-stage glyph ROM pixel pipeline.
module height_digit_renderer #(
  parameter int          VALUE_W    = 10,
  parameter int          NUM_DIGITS = 3,
  parameter int          X0         = 256,
  parameter int          Y0         = 224,
  parameter logic [5:0]  BG_COLOR   = 6'b111111,
  parameter bit          LZ_BLANK   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [VALUE_W-1:0] value,
  input  logic               value_valid,
  output logic               value_ready,
  output logic               busy,
  input  logic               frame_start,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  output logic [3:0]         glyph_sel,
  output logic [4:0]         glyph_row,
  output logic [4:0]         glyph_col,
  input  logic [5:0]         glyph_data,
  output logic [5:0]         pixel_color,
  output logic               pixel_on
);
  localparam int BW = 4*(NUM_DIGITS+1);
  localparam int DW = 4*NUM_DIGITS;
  localparam int CW = $clog2(VALUE_W+1);
  localparam logic [DW-1:0] NINES = {NUM_DIGITS{4'd9}};
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
  state_t state_q, state_d;
  logic [VALUE_W-1:0] val_q, val_d;
  logic [BW-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] pend_q, pend_d, disp_q, disp_d;
  logic pflag_q, pflag_d;
  logic [9:0] dx, dy;
  logic [4:0] p;
  logic [3:0] dig, sel_d, sel_q;
  logic in_box, blank_d, run, inb_q, blank_q;
  logic [4:0] row_q, col_q;
  logic [5:0] color_q;
  logic on_q;
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BW/4; i++)
      adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
    state_d = state_q;
    val_d = val_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    pend_d = pend_q;
    pflag_d = pflag_q;
    disp_d = disp_q;
    value_ready = state_q == IDLE;
    busy = state_q != IDLE;
    if (frame_start && pflag_q) begin
      disp_d = pend_q;
      pflag_d = 1'b0;
    end
    if (state_q == IDLE && value_valid) begin
      val_d = value;
      bcd_d = '0;
      cnt_d = CW'(VALUE_W);
      state_d = SHIFT;
    end
    if (state_q == SHIFT) begin
      {bcd_d, val_d} = {adj, val_q} << 1;
      cnt_d = cnt_q - CW'(1);
      state_d = cnt_q == CW'(1) ? LOAD : SHIFT;
    end
    // A LOAD wins over a coincident frame_start: the new digits wait a frame.
    if (state_q == LOAD) begin
      pend_d = bcd_q[BW-1-:4] != 4'd0 ? NINES : bcd_q[DW-1:0];
      pflag_d = 1'b1;
      disp_d = disp_q;
      state_d = IDLE;
    end
  end
  always_comb begin
    dx = x - 10'(X0);
    dy = y - 10'(Y0);
    p = dx[9:5];
    in_box = {1'b0, x} >= 11'(X0) && {1'b0, x} < 11'(X0 + 32*NUM_DIGITS) &&
             {1'b0, y} >= 11'(Y0) && {1'b0, y} < 11'(Y0 + 32);
    dig = '0;
    sel_d = '0;
    blank_d = 1'b0;
    run = 1'b1;
    // Position 0 is the most significant digit; run tracks "all zero so far".
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig = disp_q[4*(NUM_DIGITS-1-i)+:4];
      run = run && dig == 4'd0;
      if (in_box && p == 5'(i)) begin
        sel_d = dig;
        blank_d = LZ_BLANK && run && i != NUM_DIGITS-1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      val_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      pend_q <= '0;
      pflag_q <= 1'b0;
      disp_q <= '0;
      sel_q <= '0;
      row_q <= '0;
      col_q <= '0;
      inb_q <= 1'b0;
      blank_q <= 1'b0;
      color_q <= BG_COLOR;
      on_q <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q <= val_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      pflag_q <= pflag_d;
      disp_q <= disp_d;
      sel_q <= sel_d;
      row_q <= dy[4:0];
      col_q <= dx[4:0];
      inb_q <= in_box;
      blank_q <= blank_d;
      color_q <= inb_q && !blank_q && glyph_data != 6'h3f ? glyph_data : BG_COLOR;
      on_q <= inb_q && !blank_q && glyph_data != 6'h3f;
    end
  end
  assign glyph_sel = sel_q;
  assign glyph_row = row_q;
  assign glyph_col = col_q;
  assign pixel_color = color_q;
  assign pixel_on = on_q;
endmodule
